// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the multicycle data-memory
// controller (dmem_ctrl, dmem_lane, dmem_ctrl_if).
//   dmem_state_t : controller FSM states IDLE, REQ, WAIT, DONE
//   BUS_ERR_DATA : load result returned when a bus access times out
//   BE_WORD      : byte-lane enables for a full-word access
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'h0;
    localparam logic [3:0]  BE_WORD      = 4'hF;

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/grant/response data-memory bus.
//   master (controller): drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//                        samples mem_gnt, mem_rvalid, mem_rdata.
//   slave  (memory)    : the mirror image.
// Parameter AW: address width.
interface dmem_ctrl_if #(
    parameter int AW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane steering for dmem_ctrl.
// Optional feature macro: BYTE_ACCESS_EN (byte loads/stores). Without it the
// block is a pass-through: full-word enables, write data and read data as-is.
//   st_byte_i/st_off_i/st_wdata_i : store byte flag, byte offset, store data
//   st_be_o/st_wdata_o            : byte-lane enables and bus write data
//   ld_byte_i/ld_off_i/ld_rdata_i : load byte flag, byte offset, bus read data
//   ld_rdata_o                    : load result (zero-extended for bytes)
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        st_byte_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic        ld_byte_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_rdata_o
);

`ifdef BYTE_ACCESS_EN
    logic [7:0] ld_byte;

    // A byte store enables only its own lane and copies the low byte of the
    // store data onto every lane, so the memory picks it up wherever it lands.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign st_be_o[gi]             = st_byte_i ? (st_off_i == 2'(gi)) : 1'b1;
        assign st_wdata_o[8*gi +: 8]   = st_byte_i ? st_wdata_i[7:0]
                                                   : st_wdata_i[8*gi +: 8];
    end

    assign ld_byte    = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    assign ld_rdata_o = ld_byte_i ? {24'h0, ld_byte} : ld_rdata_i;
`else
    logic unused_lane;

    assign st_be_o     = BE_WORD;
    assign st_wdata_o  = st_wdata_i;
    assign ld_rdata_o  = ld_rdata_i;
    assign unused_lane = ^{st_byte_i, st_off_i, ld_byte_i, ld_off_i};
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multicycle data-memory controller sitting behind the
// single-cycle datapath. Turns MemWrite/MemRead into one bus transaction and
// stalls the core until the access completes (or times out).
// Optional feature macro: BYTE_ACCESS_EN (byte loads/stores via dmem_lane).
// Parameters: TIMEOUT (max REQ+WAIT cycles, 0 = no timeout), AW (address width).
// Ports:
//   clk, reset (async, active low)
//   MemWrite, MemRead, ByteEn, ALUResult, WriteData : core request
//   ReadData : load result     Stall : hold PC / suppress writebacks
//   BusErr   : sticky timeout flag
//   bus      : dmem_ctrl_if master (mem_req/we/addr/be/wdata, gnt/rvalid/rdata)
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic          ByteEn,
    input  logic [AW-1:0] ALUResult,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          BusErr,
    dmem_ctrl_if.master   bus
);

    localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit             TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    dmem_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic          byte_q;
    logic [1:0]    off_q;
    logic [31:0]   rdata_q;
    logic          buserr_q;

    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;
    logic          expired;

    dmem_lane u_lane (
        .st_byte_i  (ByteEn),
        .st_off_i   (ALUResult[1:0]),
        .st_wdata_i (WriteData),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_byte_i  (byte_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (bus.mem_rdata),
        .ld_rdata_o (ld_data)
    );

    // Last permitted REQ/WAIT cycle; a grant or rvalid in it still completes.
    assign expired = TO_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            byte_q   <= 1'b0;
            off_q    <= 2'b00;
            rdata_q  <= 32'h0;
            buserr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemWrite || MemRead) begin
                        // Write wins when both are asserted.
                        we_q    <= MemWrite;
                        req_q   <= 1'b1;
                        addr_q  <= {ALUResult[AW-1:2], 2'b00};
                        be_q    <= st_be;
                        wdata_q <= st_wdata;
                        byte_q  <= ByteEn;
                        off_q   <= ALUResult[1:0];
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.mem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? DONE : WAIT;
                    end else if (expired) begin
                        req_q    <= 1'b0;
                        buserr_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= BUS_ERR_DATA;
                        end
                        state_q  <= DONE;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.mem_rvalid) begin
                        rdata_q <= ld_data;
                        state_q <= DONE;
                    end else if (expired) begin
                        buserr_q <= 1'b1;
                        rdata_q  <= BUS_ERR_DATA;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    // One unstalled cycle lets the core commit; the still-held
                    // request is not looked at here, so it is not reissued.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stall rises in the request cycle itself; reset forces it low.
    assign Stall = reset && (((state_q == IDLE) && (MemWrite || MemRead)) ||
                             (state_q == REQ) || (state_q == WAIT));

    assign ReadData      = rdata_q;
    assign BusErr        = buserr_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. A memory responder with
// chosen grant/response delays serves each access; expected latency, bus
// fields, load data and the sticky error flag come from plain arithmetic on
// the access description. Honours BYTE_ACCESS_EN when defined.
module tb_dmem_ctrl;

    localparam int TO = 8;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          MemWrite = 1'b0;
    logic          MemRead = 1'b0;
    logic          ByteEn = 1'b0;
    logic [AW-1:0] ALUResult = '0;
    logic [31:0]   WriteData = 32'h0;
    logic [31:0]   ReadData;
    logic          Stall;
    logic          BusErr;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   rd_model = 32'h0;
    logic          err_model = 1'b0;

    always #5 clk = ~clk;

    dmem_ctrl_if #(.AW(AW)) bus ();

    dmem_ctrl #(.TIMEOUT(TO), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ByteEn    (ByteEn),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .BusErr    (BusErr),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_be(input bit byt, input logic [1:0] off);
`ifdef BYTE_ACCESS_EN
        if (byt) return 4'(1 << off);
`endif
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input bit byt, input logic [31:0] wd);
`ifdef BYTE_ACCESS_EN
        if (byt) return {4{wd[7:0]}};
`endif
        return wd;
    endfunction

    function automatic logic [31:0] exp_rdata(input bit byt, input logic [1:0] off,
                                              input logic [31:0] rd);
`ifdef BYTE_ACCESS_EN
        if (byt) return (rd >> (8 * off)) & 32'hFF;
`endif
        return rd;
    endfunction

    // One core access. Called at a negedge; returns at the negedge after DONE.
    // g = REQ cycles without grant, r = WAIT cycles without rvalid.
    task automatic run_txn(input bit wr, input bit rd, input bit byt,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdat, input int g, input int r);
        int  lat, exp_lat, reqs, waits;
        bit  granted, tmo, done;
        if (wr) tmo = (TO != 0) && (g >= TO);
        else    tmo = (TO != 0) && (g + r + 2 > TO);
        exp_lat = tmo ? 1 + TO : (wr ? 2 + g : 3 + g + r);
        MemWrite = wr; MemRead = rd; ByteEn = byt; ALUResult = addr; WriteData = wd;
        lat = 0; reqs = 0; waits = 0; granted = 0; done = 0;
        for (int k = 0; k < 4 * TO + 40 && !done; k++) begin
            #1;
            if (Stall) begin
                lat++;
                bus.mem_gnt = 1'b0;
                bus.mem_rvalid = 1'b0;
                if (bus.mem_req) begin
                    if (reqs == 0) begin
                        chk("mem_we", 32'(bus.mem_we), 32'(wr));
                        chk("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                        if (wr) begin
                            chk("mem_be", 32'(bus.mem_be), 32'(exp_be(byt, addr[1:0])));
                            chk("mem_wdata", bus.mem_wdata, exp_wdata(byt, wd));
                        end
                    end
                    if (reqs == g) begin
                        bus.mem_gnt = 1'b1;
                    end else if ($urandom_range(0, 3) == 0) begin
                        bus.mem_rvalid = 1'b1;          // stray, must be ignored
                        bus.mem_rdata = $urandom;
                    end
                    reqs++;
                end else if (granted) begin
                    if (waits == r) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata = rdat;
                    end
                    waits++;
                end
                @(posedge clk);
                if (bus.mem_gnt) granted = 1;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        chk("stall_released", 32'(done), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        if (tmo) err_model = 1'b1;
        if (!wr) rd_model = tmo ? 32'h0 : exp_rdata(byt, addr[1:0], rdat);
        chk("ReadData", ReadData, rd_model);
        chk("BusErr", 32'(BusErr), 32'(err_model));
        chk("mem_req_done", 32'(bus.mem_req), 32'd0);
        MemWrite = 1'b0; MemRead = 1'b0;
        @(negedge clk);
        #1;
        chk("no_reissue", {30'h0, Stall, bus.mem_req}, 32'h0);
        $display("txn %s%s addr=%h wd=%h g=%0d r=%0d lat=%0d rd=%h err=%0b",
                 wr ? "W" : "R", byt ? "B" : " ", addr, wd, g, r, lat, ReadData, BusErr);
        @(negedge clk);
    endtask

    task automatic reset_mid_wait();
        MemRead = 1'b1; ALUResult = 32'h300;
        @(posedge clk);                 // IDLE -> REQ
        @(negedge clk); bus.mem_gnt = 1'b1;
        @(posedge clk);                 // REQ -> WAIT
        @(negedge clk); bus.mem_gnt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_buserr", 32'(BusErr), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        err_model = 1'b0; rd_model = 32'h0;
        @(negedge clk);
        MemRead = 1'b0; reset = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("stray_rvalid_rd", ReadData, 32'h0);
        chk("stray_rvalid_req", {31'h0, bus.mem_req}, 32'h0);
        $display("txn RST mid-WAIT rd=%h req=%0b", ReadData, bus.mem_req);
        @(negedge clk);
    endtask

    initial begin
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        MemWrite = 1'b1;                // must not raise Stall during reset
        #12;
        chk("rst_ReadData", ReadData, 32'h0);
        chk("rst_BusErr", 32'(BusErr), 32'd0);
        chk("rst_Stall", 32'(Stall), 32'd0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr0", bus.mem_addr, 32'h0);
        chk("rst_be", 32'(bus.mem_be), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        MemWrite = 1'b0; reset = 1'b1;
        @(negedge clk);

        run_txn(1, 0, 0, 32'h100, 32'hCAFE_F00D, 32'h0, 0, 0);
        run_txn(0, 1, 0, 32'h104, 32'h0, 32'h1234_5678, 2, 2);
        run_txn(1, 1, 0, 32'h108, 32'h5555_AAAA, 32'h0, 1, 0);
        run_txn(1, 0, 0, 32'h10C, 32'h0BAD_CAFE, 32'h0, TO - 1, 0);
        run_txn(0, 1, 0, 32'h110, 32'h0, 32'h0F0F_0F0F, 1, TO - 3);
        run_txn(1, 0, 1, 32'h203, 32'h0000_00AB, 32'h0, 0, 0);
        run_txn(0, 1, 1, 32'h202, 32'h0, 32'h1122_3344, 0, 1);
        run_txn(0, 1, 0, 32'h114, 32'h0, 32'h7777_7777, TO, 0);
        run_txn(0, 1, 0, 32'h118, 32'h0, 32'h8888_8888, 0, TO);
        run_txn(1, 0, 0, 32'h11C, 32'h1, 32'h0, 0, 0);
        reset_mid_wait();

        for (int n = 0; n < 40; n++) begin
            int op, g, r;
            op = $urandom_range(0, 2);
            g  = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
            r  = $urandom_range(0, 5);
            run_txn(op != 1, op != 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom, g, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Multicycle data-memory controller directly downstream of the single-cycle datapath.
- Consumes the datapath's ALUResult (address), WriteData and the MemWrite/MemRead controls.
- Drives a request/grant/response memory bus, returns ReadData, and stalls the core (holds PC and register writes) until the access completes.
- Replaces the ideal zero-latency dmem so slow or shared memory can be attached.

Parameters:
- TIMEOUT, 16: max cycles spent in REQ+WAIT before aborting with bus error; 0 disables the timeout.
- AW, 32: address width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- MemWrite  in  1  store request from control unit.
- MemRead  in  1  load request from control unit.
- ByteEn  in  1  byte access (LDRB/STRB); used only with BYTE_ACCESS_EN.
- ALUResult  in  AW  effective address.
- WriteData  in  32  store data.
- ReadData  out  32  load result to result mux.
- Stall  out  1  core must hold PC and suppress register/flag writes.
- BusErr  out  1  sticky bus-timeout flag.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  AW  word-aligned address {addr[AW-1:2],2'b00}.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
Reset values: state IDLE; ReadData 0; BusErr 0; mem_req 0; mem_we 0; mem_addr 0; mem_be 0; mem_wdata 0; counter 0.

State machine (IDLE, REQ, WAIT, DONE):
- IDLE
  - MemWrite|MemRead: latch address, wdata, be and we into bus registers; next state REQ. Stall=1 combinationally in this cycle.
  - Otherwise: Stall=0.
- REQ
  - mem_req=1; bus outputs held stable until grant.
  - mem_gnt with write: DONE. mem_gnt with read: WAIT.
- WAIT
  - mem_rvalid: ReadData<=mem_rdata (lane-aligned); next state DONE.
  - mem_rvalid never arrives in the grant cycle; rvalid seen while in REQ is ignored.
- DONE
  - Stall=0 for exactly one cycle; core commits the instruction; next state IDLE.
  - Guarantees a held request is not reissued.
- Stall=1 in REQ and WAIT.

Timing and arbitration:
- Latency: store = 2 + grant wait cycles; load = 3 + grant wait + response wait cycles (request cycle to Stall low).
- MemWrite and MemRead both high: write wins; read ignored.

Timeout counter:
- Clears on entry to REQ; increments each cycle in REQ/WAIT.
- When count == TIMEOUT-1 with no completing event: mem_req drops, BusErr<=1, ReadData<=32'h0 for loads, next state DONE.
- A completing event (gnt or rvalid) in the same cycle as expiry wins over the timeout.
- BusErr clears only on reset.

Reset:
- Reset assertion at any time (mid-REQ/WAIT) returns all state to reset values asynchronously.
- The pending access is abandoned; any late mem_rvalid is ignored in IDLE.
- Stall is low during reset.

Optional Feature:
BYTE_ACCESS_EN
- Defined, ByteEn=1 store: mem_be = 4'b0001 << addr[1:0]; mem_wdata = WriteData[7:0] replicated to all four lanes.
- Defined, ByteEn=1 load: ReadData = zero-extended byte addr[1:0] of mem_rdata.
- Undefined: ByteEn ignored; mem_be=4'hF; ReadData=mem_rdata; addr[1:0] dropped.

Decomposition:
- Package dmem_pkg: state enum dmem_state_t {IDLE, REQ, WAIT, DONE}; BUS_ERR_DATA = 32'h0.
- One sub-module dmem_lane: combinational byte-enable/write-replication/read-extraction logic, compiled under BYTE_ACCESS_EN; pass-through otherwise.
- FSM and counter stay in dmem_ctrl.

Test Plan:
- Store addr 0x100, data 0xCAFEF00D, grant 1 cycle after req: mem_we=1, mem_addr=0x100, mem_be=F; Stall high 2 cycles, low the next.
- Load addr 0x104, grant after 2 waits, rvalid 3 cycles later with 0x12345678: ReadData=0x12345678 in DONE; Stall low exactly one cycle.
- Load with no grant, TIMEOUT=4: after 4 REQ cycles mem_req drops, BusErr=1 (sticky), ReadData=0, DONE then IDLE.
- Reset (reset=0) asserted mid-WAIT: mem_req=0, Stall=0 immediately; subsequent stray rvalid leaves ReadData=0.
- BYTE_ACCESS_EN: STRB 0xAB to 0x203 gives mem_be=4'b1000, wdata=0xABABABAB; LDRB from 0x202 with rdata 0x11223344 gives ReadData=0x22.
- MemWrite and MemRead both high: single write transaction issued, no read.
